// File: rtl/tilelink_ul_master_if.sv
// TileLink-UL A/D channel bundle shared by the master and its slave.
// The master modport drives the A channel and d_ready; the slave modport
// drives a_ready and the D channel.
interface tilelink_ul_master_if #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8
);
    // A channel
    logic                       a_valid;
    logic                       a_ready;
    logic [TL_OPCODE_WIDTH-1:0] a_opcode;
    logic [TL_PARAM_WIDTH-1:0]  a_param;
    logic [TL_ADDR_WIDTH-1:0]   a_address;
    logic [TL_SIZE_WIDTH-1:0]   a_size;
    logic [TL_STRB_WIDTH-1:0]   a_mask;
    logic [TL_DATA_WIDTH-1:0]   a_data;
    logic [TL_SOURCE_WIDTH-1:0] a_source;

    // D channel
    logic                       d_valid;
    logic                       d_ready;
    logic [TL_OPCODE_WIDTH-1:0] d_opcode;
    logic [TL_PARAM_WIDTH-1:0]  d_param;
    logic [TL_SIZE_WIDTH-1:0]   d_size;
    logic [TL_SINK_WIDTH-1:0]   d_sink;
    logic [TL_SOURCE_WIDTH-1:0] d_source;
    logic [TL_DATA_WIDTH-1:0]   d_data;
    logic                       d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        input  d_ready
    );
endinterface

// File: rtl/tilelink_ul_master.sv
// TileLink-UL master: turns a local request/response port into one A beat
// and one D beat at a time. Source IDs roll 0..2^W-1 per completed request.
// Optional D-wait timeout is built when TL_MASTER_TIMEOUT_EN is defined;
// without it the master waits for the D response indefinitely.
module tilelink_ul_master #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    // local request
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [TL_ADDR_WIDTH-1:0] req_addr,
    input  logic [TL_SIZE_WIDTH-1:0] req_size,
    input  logic [TL_STRB_WIDTH-1:0] req_mask,
    input  logic [TL_DATA_WIDTH-1:0] req_wdata,
    // local response
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [TL_DATA_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_error,
    // TileLink A/D channels
    tilelink_ul_master_if.master     tl
);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_FULL    = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = TL_OPCODE_WIDTH'(1);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_GET         = TL_OPCODE_WIDTH'(4);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK         = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK_DATA    = TL_OPCODE_WIDTH'(1);
    // Largest transfer that fits in one data beat.
    localparam logic [TL_SIZE_WIDTH-1:0]   MAX_SIZE       = TL_SIZE_WIDTH'($clog2(TL_STRB_WIDTH));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_A_SEND = 2'd1,
        S_D_WAIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                     state_q;
    logic                       a_valid_q;
    logic [TL_OPCODE_WIDTH-1:0] a_opcode_q;
    logic [TL_PARAM_WIDTH-1:0]  a_param_q;
    logic [TL_ADDR_WIDTH-1:0]   a_address_q;
    logic [TL_SIZE_WIDTH-1:0]   a_size_q;
    logic [TL_STRB_WIDTH-1:0]   a_mask_q;
    logic [TL_DATA_WIDTH-1:0]   a_data_q;
    logic [TL_SOURCE_WIDTH-1:0] a_source_q;
    logic [TL_SOURCE_WIDTH-1:0] src_cnt_q;
    logic                       d_ready_q;
    logic                       rsp_valid_q;
    logic                       rsp_error_q;
    logic [TL_DATA_WIDTH-1:0]   rsp_rdata_q;

`ifdef TL_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    logic                       is_get;
    logic [TL_OPCODE_WIDTH-1:0] exp_d_opcode;
    logic                       d_resp_bad;

    // Response checks against the request currently in flight.
    assign is_get       = (a_opcode_q == OP_GET);
    assign exp_d_opcode = is_get ? OP_ACK_DATA : OP_ACK;
    assign d_resp_bad   = tl.d_error
                        | (tl.d_source != a_source_q)
                        | (tl.d_opcode != exp_d_opcode);

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_error    = rsp_error_q;

    assign tl.a_valid   = a_valid_q;
    assign tl.a_opcode  = a_opcode_q;
    assign tl.a_param   = a_param_q;
    assign tl.a_address = a_address_q;
    assign tl.a_size    = a_size_q;
    assign tl.a_mask    = a_mask_q;
    assign tl.a_data    = a_data_q;
    assign tl.a_source  = a_source_q;
    assign tl.d_ready   = d_ready_q;

    // Transaction FSM with all channel outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_param_q   <= '0;
            a_address_q <= '0;
            a_size_q    <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            a_source_q  <= '0;
            src_cnt_q   <= '0;
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef TL_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_opcode_q  <= !req_write ? OP_GET
                                     : (&req_mask ? OP_PUT_FULL : OP_PUT_PARTIAL);
                        a_param_q   <= '0;
                        a_address_q <= req_addr;
                        a_size_q    <= req_size;
                        a_mask_q    <= req_mask;
                        a_data_q    <= req_write ? req_wdata : '0;
                        a_source_q  <= src_cnt_q;
                        if (req_size > MAX_SIZE) begin
                            // Oversized: answer locally with an error, no A beat.
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= S_RESP;
                        end else begin
                            a_valid_q <= 1'b1;
                            state_q   <= S_A_SEND;
                        end
                    end
                end
                S_A_SEND: begin
                    if (tl.a_ready) begin
                        a_valid_q <= 1'b0;
                        d_ready_q <= 1'b1;
                        state_q   <= S_D_WAIT;
`ifdef TL_MASTER_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                S_D_WAIT: begin
                    // A response arriving on the expiry cycle still wins.
                    if (tl.d_valid) begin
                        d_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= d_resp_bad;
                        rsp_rdata_q <= is_get ? tl.d_data : '0;
                        state_q     <= S_RESP;
                    end
`ifdef TL_MASTER_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        d_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        src_cnt_q   <= src_cnt_q + 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tilelink_ul_master.sv
// Directed testbench for tilelink_ul_master. The bench plays the TileLink
// slave and the local requester; outputs are sampled 1 ns after each rising
// edge. Define TL_MASTER_TIMEOUT_EN to also exercise the D-wait timeout.
module tb_tilelink_ul_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [7:0]  req_size;
    logic [7:0]  req_mask;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [2:0]  exp_src;

    tilelink_ul_master_if tl_bus ();

    tilelink_ul_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .tl        (tl_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; caller ensures the DUT is idle.
    task automatic accept_req(input logic wr, input logic [63:0] addr, input logic [7:0] size,
                              input logic [7:0] mask, input logic [63:0] wdata);
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_mask  = mask;
        req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic a_handshake();
        tl_bus.a_ready = 1'b1;
        tick();
        tl_bus.a_ready = 1'b0;
    endtask

    task automatic d_respond(input logic [2:0] op, input logic [2:0] src, input logic err,
                             input logic [63:0] data);
        tl_bus.d_valid  = 1'b1;
        tl_bus.d_opcode = op;
        tl_bus.d_source = src;
        tl_bus.d_error  = err;
        tl_bus.d_data   = data;
        tick();
        tl_bus.d_valid  = 1'b0;
        tl_bus.d_error  = 1'b0;
    endtask

    task automatic finish_rsp();
        $display("txn src=%0d rsp_error=%0b rsp_rdata=%h", exp_src, rsp_error, rsp_rdata);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_src   = exp_src + 3'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (tl_bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b want 0", tl_bus.a_valid); end
        n_checks++; if (tl_bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_d_ready: got %b want 0", tl_bus.d_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_error: got %b want 0", rsp_error); end
        n_checks++; if (rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (tl_bus.a_address !== 64'h0 || tl_bus.a_opcode !== 3'd0 || tl_bus.a_source !== 3'd0)
            begin n_fail++; $display("FAIL rst_a_fields: addr %h op %0d src %0d want all 0", tl_bus.a_address, tl_bus.a_opcode, tl_bus.a_source); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        rst = 1'b1;
        exp_src = 3'd0;
        tick();
    endtask

    task automatic test_write_full();
        accept_req(1'b1, 64'h10, 8'd3, 8'hFF, 64'hDEADBEEF_CAFEBABE);
        n_checks++; if (tl_bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL wf_a_valid: got %b want 1", tl_bus.a_valid); end
        n_checks++; if (tl_bus.a_opcode !== 3'd0) begin n_fail++; $display("FAIL wf_opcode: got %0d want 0", tl_bus.a_opcode); end
        n_checks++; if (tl_bus.a_source !== 3'd0) begin n_fail++; $display("FAIL wf_source: got %0d want 0", tl_bus.a_source); end
        n_checks++; if (tl_bus.a_address !== 64'h10 || tl_bus.a_size !== 8'd3 || tl_bus.a_mask !== 8'hFF || tl_bus.a_param !== 3'd0)
            begin n_fail++; $display("FAIL wf_fields: addr %h size %0d mask %h param %0d", tl_bus.a_address, tl_bus.a_size, tl_bus.a_mask, tl_bus.a_param); end
        n_checks++; if (tl_bus.a_data !== 64'hDEADBEEF_CAFEBABE) begin n_fail++; $display("FAIL wf_data: got %h want deadbeefcafebabe", tl_bus.a_data); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wf_req_ready: got %b want 0", req_ready); end
        a_handshake();
        n_checks++; if (tl_bus.a_valid !== 1'b0 || tl_bus.d_ready !== 1'b1)
            begin n_fail++; $display("FAIL wf_after_a: a_valid %b d_ready %b want 0/1", tl_bus.a_valid, tl_bus.d_ready); end
        d_respond(3'd0, 3'd0, 1'b0, 64'h1111_2222_3333_4444);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0)
            begin n_fail++; $display("FAIL wf_rsp: valid %b error %b want 1/0", rsp_valid, rsp_error); end
        n_checks++; if (rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL wf_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (tl_bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL wf_d_ready_drop: got %b want 0", tl_bus.d_ready); end
        finish_rsp();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin n_fail++; $display("FAIL wf_idle: rsp_valid %b req_ready %b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_read();
        accept_req(1'b0, 64'h10, 8'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        n_checks++; if (tl_bus.a_opcode !== 3'd4) begin n_fail++; $display("FAIL rd_opcode: got %0d want 4", tl_bus.a_opcode); end
        n_checks++; if (tl_bus.a_data !== 64'h0) begin n_fail++; $display("FAIL rd_a_data: got %h want 0", tl_bus.a_data); end
        n_checks++; if (tl_bus.a_source !== 3'd1) begin n_fail++; $display("FAIL rd_source: got %0d want 1", tl_bus.a_source); end
        a_handshake();
        d_respond(3'd1, 3'd1, 1'b0, 64'hDEADBEEF_CAFEBABE);
        n_checks++; if (rsp_rdata !== 64'hDEADBEEF_CAFEBABE) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeefcafebabe", rsp_rdata); end
        n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL rd_error: got %b want 0", rsp_error); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_CAFEBABE)
            begin n_fail++; $display("FAIL rd_hold: valid %b rdata %h want held", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_partial_write();
        accept_req(1'b1, 64'h20, 8'd2, 8'h0F, 64'h0123_4567_89AB_CDEF);
        // A plausible D beat while still in A_SEND must be ignored.
        tl_bus.d_valid  = 1'b1;
        tl_bus.d_opcode = 3'd0;
        tl_bus.d_source = exp_src;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (tl_bus.a_valid !== 1'b1 || tl_bus.a_opcode !== 3'd1)
                begin n_fail++; $display("FAIL pw_stall%0d: a_valid %b opcode %0d want 1/1", i, tl_bus.a_valid, tl_bus.a_opcode); end
            n_checks++; if (tl_bus.a_data !== 64'h0123_4567_89AB_CDEF || tl_bus.a_mask !== 8'h0F || tl_bus.a_address !== 64'h20 || tl_bus.a_source !== exp_src)
                begin n_fail++; $display("FAIL pw_stable%0d: data %h mask %h addr %h src %0d", i, tl_bus.a_data, tl_bus.a_mask, tl_bus.a_address, tl_bus.a_source); end
            n_checks++; if (tl_bus.d_ready !== 1'b0 || rsp_valid !== 1'b0)
                begin n_fail++; $display("FAIL pw_d_ignored%0d: d_ready %b rsp_valid %b want 0/0", i, tl_bus.d_ready, rsp_valid); end
            tick();
        end
        tl_bus.d_valid = 1'b0;
        a_handshake();
        tick();
        n_checks++; if (tl_bus.a_valid !== 1'b0 || tl_bus.d_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL pw_single_beat: a_valid %b d_ready %b rsp_valid %b want 0/1/0", tl_bus.a_valid, tl_bus.d_ready, rsp_valid); end
        d_respond(3'd0, exp_src, 1'b0, 64'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0)
            begin n_fail++; $display("FAIL pw_rsp: valid %b error %b want 1/0", rsp_valid, rsp_error); end
        finish_rsp();
    endtask

    task automatic test_resp_errors();
        logic [2:0]  op;
        logic [2:0]  src;
        logic        err;
        logic [63:0] data;
        for (int c = 0; c < 3; c++) begin
            op   = (c == 2) ? 3'd0 : 3'd1;
            src  = (c == 0) ? exp_src + 3'd3 : exp_src;
            err  = (c == 1);
            data = 64'hA5A5_0000_0000_0000 | 64'(c);
            accept_req(1'b0, 64'h100, 8'd2, 8'h0F, 64'h0);
            a_handshake();
            d_respond(op, src, err, data);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1)
                begin n_fail++; $display("FAIL err_case%0d: valid %b error %b want 1/1", c, rsp_valid, rsp_error); end
            n_checks++; if (rsp_rdata !== data)
                begin n_fail++; $display("FAIL err_rdata%0d: got %h want %h", c, rsp_rdata, data); end
            finish_rsp();
        end
    endtask

    task automatic test_size_error();
        accept_req(1'b0, 64'h40, 8'd4, 8'hFF, 64'h0);
        n_checks++; if (tl_bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL sz_no_a: a_valid %b want 0", tl_bus.a_valid); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 64'h0)
            begin n_fail++; $display("FAIL sz_rsp: valid %b error %b rdata %h want 1/1/0", rsp_valid, rsp_error, rsp_rdata); end
        tick();
        n_checks++; if (tl_bus.a_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== 1'b1)
            begin n_fail++; $display("FAIL sz_hold: a_valid %b rsp_valid %b error %b want 0/1/1", tl_bus.a_valid, rsp_valid, rsp_error); end
        finish_rsp();
        // The error path still consumes a source ID.
        accept_req(1'b1, 64'h48, 8'd0, 8'h01, 64'h55);
        n_checks++; if (tl_bus.a_source !== exp_src || tl_bus.a_opcode !== 3'd1)
            begin n_fail++; $display("FAIL sz_next_src: src %0d opcode %0d want %0d/1", tl_bus.a_source, tl_bus.a_opcode, exp_src); end
        a_handshake();
        d_respond(3'd0, exp_src, 1'b0, 64'h0);
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_src = 3'd0;
        tick();
        req_write = 1'b0; req_addr = 64'h200; req_size = 8'd3; req_mask = 8'hFF; req_wdata = 64'h0;
        req_valid = 1'b1; tl_bus.a_ready = 1'b1; rsp_ready = 1'b1;
        tl_bus.d_valid = 1'b1; tl_bus.d_opcode = 3'd1; tl_bus.d_error = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tl_bus.d_data = 64'hB2B0_0000_0000_0000 + 64'(k);
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle%0d: req_ready %b want 1", k, req_ready); end
            tick();
            n_checks++; if (tl_bus.a_valid !== 1'b1 || tl_bus.a_source !== 3'(k))
                begin n_fail++; $display("FAIL b2b_src%0d: a_valid %b src %0d want 1/%0d", k, tl_bus.a_valid, tl_bus.a_source, k % 8); end
            tl_bus.d_source = 3'(k);
            tick();
            n_checks++; if (tl_bus.d_ready !== 1'b1 || tl_bus.a_valid !== 1'b0)
                begin n_fail++; $display("FAIL b2b_dwait%0d: d_ready %b a_valid %b want 1/0", k, tl_bus.d_ready, tl_bus.a_valid); end
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 64'hB2B0_0000_0000_0000 + 64'(k))
                begin n_fail++; $display("FAIL b2b_rsp%0d: valid %b error %b rdata %h", k, rsp_valid, rsp_error, rsp_rdata); end
            $display("txn src=%0d rsp_error=%0b rsp_rdata=%h", k % 8, rsp_error, rsp_rdata);
            tick();
        end
        req_valid = 1'b0; tl_bus.a_ready = 1'b0; rsp_ready = 1'b0; tl_bus.d_valid = 1'b0;
        exp_src = 3'd1;
        tick();
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL b2b_end: req_ready %b rsp_valid %b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_asend();
        accept_req(1'b1, 64'h300, 8'd3, 8'hFF, 64'h77);
        n_checks++; if (tl_bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre: a_valid %b want 1", tl_bus.a_valid); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (tl_bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async: a_valid %b want 0", tl_bus.a_valid); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || tl_bus.d_ready !== 1'b0)
            begin n_fail++; $display("FAIL rm_idle: req_ready %b rsp_valid %b d_ready %b want 1/0/0", req_ready, rsp_valid, tl_bus.d_ready); end
        #3 rst = 1'b1;
        exp_src = 3'd0;
        tick();
        n_checks++; if (tl_bus.a_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin n_fail++; $display("FAIL rm_after: a_valid %b rsp_valid %b req_ready %b want 0/0/1", tl_bus.a_valid, rsp_valid, req_ready); end
        accept_req(1'b0, 64'h308, 8'd3, 8'hFF, 64'h0);
        n_checks++; if (tl_bus.a_source !== 3'd0) begin n_fail++; $display("FAIL rm_src: got %0d want 0", tl_bus.a_source); end
        a_handshake();
        d_respond(3'd1, 3'd0, 1'b0, 64'hC0FFEE);
        n_checks++; if (rsp_rdata !== 64'hC0FFEE || rsp_error !== 1'b0)
            begin n_fail++; $display("FAIL rm_rsp: rdata %h error %b want c0ffee/0", rsp_rdata, rsp_error); end
        finish_rsp();
    endtask

`ifdef TL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        accept_req(1'b0, 64'h400, 8'd3, 8'hFF, 64'h0);
        a_handshake();
        repeat (15) tick();
        n_checks++; if (rsp_valid !== 1'b0 || tl_bus.d_ready !== 1'b1)
            begin n_fail++; $display("FAIL to_early: rsp_valid %b d_ready %b want 0/1", rsp_valid, tl_bus.d_ready); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 64'h0 || tl_bus.d_ready !== 1'b0)
            begin n_fail++; $display("FAIL to_expire: valid %b error %b rdata %h d_ready %b", rsp_valid, rsp_error, rsp_rdata, tl_bus.d_ready); end
        finish_rsp();
        accept_req(1'b0, 64'h408, 8'd3, 8'hFF, 64'h0);
        a_handshake();
        repeat (15) tick();
        d_respond(3'd1, exp_src, 1'b0, 64'h5EED);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 64'h5EED)
            begin n_fail++; $display("FAIL to_race: valid %b error %b rdata %h want 1/0/5eed", rsp_valid, rsp_error, rsp_rdata); end
        finish_rsp();
    endtask
`endif

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_mask = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        tl_bus.a_ready = 1'b0; tl_bus.d_valid = 1'b0; tl_bus.d_opcode = '0; tl_bus.d_param = '0;
        tl_bus.d_size = '0; tl_bus.d_sink = '0; tl_bus.d_source = '0; tl_bus.d_data = '0; tl_bus.d_error = 1'b0;
        exp_src = 3'd0;
        test_reset();
        test_write_full();
        test_read();
        test_partial_write();
        test_resp_errors();
        test_size_error();
        test_back_to_back();
        test_reset_mid_asend();
`ifdef TL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, test sequence incomplete");
        $fatal(1);
    end
endmodule
